// File: rtl/slow_pulse_arbiter_pkg.sv
// Shared types and the round-robin selection helper for slow_pulse_arbiter.
// rr_pick is written over a fixed maximum width so one function serves any NUM_REQ.
package slow_pulse_arb_pkg;

    typedef enum logic {IDLE, GRANT} arb_state_t;

    localparam int MAX_REQ = 32;

    typedef struct packed {
        logic       found;
        logic [7:0] idx;
    } rr_pick_t;

    // Scan from rr_ptr+1 upward with wrap; the smallest offset that hits wins.
    function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] pend,
                                         input int num_req,
                                         input int rr_ptr);
        rr_pick_t r;
        int       idx;
        r = '0;
        for (int k = MAX_REQ; k >= 1; k--) begin
            if (k <= num_req) begin
                idx = rr_ptr + k;
                if (idx >= num_req) idx = idx - num_req;
                if (pend[idx[4:0]]) begin
                    r.found = 1'b1;
                    r.idx   = idx[7:0];
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/slow_pulse_arbiter_sync.sv
// Per-channel synchronizer chain plus rising-edge detector into fast_clk.
// evt is a one-cycle strobe taken between the last sync flop and a delay flop.
module pulse_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic fast_clk,
    input  logic rst_n,
    input  logic async_in,
    output logic evt
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_dly;

    always_ff @(posedge fast_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
            r_dly  <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], async_in};
            r_dly  <= r_sync[SYNC_STAGES-1];
        end
    end

    assign evt = r_sync[SYNC_STAGES-1] & ~r_dly;

endmodule

// File: rtl/slow_pulse_arbiter.sv
// Collects slow-domain request pulses as pending bits and grants them one at a
// time, round-robin, to a single fast-domain consumer over valid/ready.
module slow_pulse_arbiter #(
    parameter  int NUM_REQ     = 4,
    parameter  int SYNC_STAGES = 2,
    localparam int ID_W        = $clog2(NUM_REQ)
) (
    input  logic               fast_clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] slow_pulse,
    output logic               gnt_valid,
    output logic [ID_W-1:0]    gnt_id,
    input  logic               gnt_ready,
    output logic [NUM_REQ-1:0] pending,
    output logic [NUM_REQ-1:0] overflow,
    input  logic [NUM_REQ-1:0] ovf_clr
);
    import slow_pulse_arb_pkg::*;

    logic [NUM_REQ-1:0] w_evt;
    logic [NUM_REQ-1:0] w_accept;
    logic [NUM_REQ-1:0] w_pending;
    logic [NUM_REQ-1:0] w_overflow;
    logic [MAX_REQ-1:0] w_pend_ext;
    rr_pick_t           w_pick;

    arb_state_t         r_state;
    logic               r_gnt_valid;
    logic [ID_W-1:0]    r_gnt_id;
    logic [ID_W-1:0]    r_rr_ptr;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_chan
            logic r_pend_bit;
            logic r_ovf_bit;

            pulse_sync_edge #(
                .SYNC_STAGES(SYNC_STAGES)
            ) u_sync (
                .fast_clk(fast_clk),
                .rst_n   (rst_n),
                .async_in(slow_pulse[gi]),
                .evt     (w_evt[gi])
            );

            assign w_accept[gi] = r_gnt_valid & gnt_ready & (r_gnt_id == ID_W'(gi));

            // A fresh event on the cycle its predecessor is consumed simply re-arms the bit.
            always_ff @(posedge fast_clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_pend_bit <= 1'b0;
                    r_ovf_bit  <= 1'b0;
                end else begin
                    if (w_evt[gi] && w_accept[gi]) begin
                        r_pend_bit <= 1'b1;
                    end else if (w_evt[gi] && r_pend_bit) begin
                        r_ovf_bit  <= 1'b1;
                    end else if (w_evt[gi]) begin
                        r_pend_bit <= 1'b1;
                    end else if (w_accept[gi]) begin
                        r_pend_bit <= 1'b0;
                    end

                    if (ovf_clr[gi] && !(w_evt[gi] && r_pend_bit && !w_accept[gi])) begin
                        r_ovf_bit <= 1'b0;
                    end
                end
            end

            assign w_pending[gi]  = r_pend_bit;
            assign w_overflow[gi] = r_ovf_bit;
        end
    endgenerate

    always_comb begin
        w_pend_ext                = '0;
        w_pend_ext[NUM_REQ-1:0]   = w_pending;
        w_pick                    = rr_pick(w_pend_ext, NUM_REQ, int'(r_rr_ptr));
    end

    always_ff @(posedge fast_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_gnt_valid <= 1'b0;
            r_gnt_id    <= '0;
            r_rr_ptr    <= ID_W'(NUM_REQ - 1);
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pick.found) begin
                        r_gnt_id    <= w_pick.idx[ID_W-1:0];
                        r_gnt_valid <= 1'b1;
                        r_state     <= GRANT;
                    end
                end
                GRANT: begin
                    if (gnt_ready) begin
                        r_gnt_valid <= 1'b0;
                        r_rr_ptr    <= r_gnt_id;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_gnt_valid <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign gnt_valid = r_gnt_valid;
    assign gnt_id    = r_gnt_id;
    assign pending   = w_pending;
    assign overflow  = w_overflow;

endmodule

// File: tb/tb_slow_pulse_arbiter.sv
// Directed bench for slow_pulse_arbiter: sync latency, round-robin order,
// hold under backpressure, overflow set/clear, accept/event collision, async reset.
module tb_slow_pulse_arbiter;

    logic       fast_clk = 1'b0;
    logic       rst_n;
    logic [3:0] slow_pulse;
    logic       gnt_valid;
    logic [1:0] gnt_id;
    logic       gnt_ready;
    logic [3:0] pending;
    logic [3:0] overflow;
    logic [3:0] ovf_clr;

    int n_pass  = 0;
    int n_total = 0;

    slow_pulse_arbiter #(
        .NUM_REQ    (4),
        .SYNC_STAGES(2)
    ) dut (
        .fast_clk  (fast_clk),
        .rst_n     (rst_n),
        .slow_pulse(slow_pulse),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id),
        .gnt_ready (gnt_ready),
        .pending   (pending),
        .overflow  (overflow),
        .ovf_clr   (ovf_clr)
    );

    always #5 fast_clk = ~fast_clk;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge fast_clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    // One grant cycle then the mandatory idle bubble, with gnt_ready held high.
    task automatic expect_grant(input int id);
        tick();
        check("grant_valid", 32'(gnt_valid), 1);
        check("grant_id", 32'(gnt_id), id);
        $display("grant id=%0d at %0t", gnt_id, $time);
        tick();
        check("grant_bubble", 32'(gnt_valid), 0);
    endtask

    task automatic do_reset();
        slow_pulse = '0;
        ovf_clr    = '0;
        gnt_ready  = 1'b0;
        rst_n      = 1'b0;
        ticks(3);
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        // Reset state
        do_reset();
        check("rst_valid", 32'(gnt_valid), 0);
        check("rst_pending", 32'(pending), 0);
        check("rst_overflow", 32'(overflow), 0);

        // Single ch2 pulse: pending two edges after first sample, grant one edge later
        gnt_ready  = 1'b1;
        slow_pulse = 4'b0100;
        ticks(2);
        check("t2_pend_early", 32'(pending), 0);
        tick();
        check("t2_pend_set", 32'(pending), 4'b0100);
        check("t2_no_grant_yet", 32'(gnt_valid), 0);
        tick();
        check("t2_valid", 32'(gnt_valid), 1);
        check("t2_id", 32'(gnt_id), 2);
        tick();
        check("t2_valid_drop", 32'(gnt_valid), 0);
        check("t2_pend_clr", 32'(pending), 0);

        // Simultaneous 0,1,3 from fresh reset: order 0,1,3
        do_reset();
        gnt_ready  = 1'b1;
        slow_pulse = 4'b1011;
        ticks(3);
        check("t3_pend", 32'(pending), 4'b1011);
        expect_grant(0);
        expect_grant(1);
        expect_grant(3);
        check("t3_pend_empty", 32'(pending), 0);
        slow_pulse = 4'b0000;
        ticks(4);
        slow_pulse = 4'b1001;
        ticks(3);
        check("t3b_pend", 32'(pending), 4'b1001);
        expect_grant(0);
        expect_grant(3);
        slow_pulse = 4'b0000;
        ticks(4);

        // Backpressure on ch1, second pulse overflows, then clear
        gnt_ready  = 1'b0;
        slow_pulse = 4'b0010;
        ticks(3);
        check("t4_pend", 32'(pending), 4'b0010);
        tick();
        check("t4_valid", 32'(gnt_valid), 1);
        check("t4_id", 32'(gnt_id), 1);
        slow_pulse = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t4_hold_valid", 32'(gnt_valid), 1);
            check("t4_hold_id", 32'(gnt_id), 1);
        end
        slow_pulse = 4'b0010;
        ticks(2);
        check("t4_ovf_early", 32'(overflow), 0);
        tick();
        check("t4_ovf_set", 32'(overflow), 4'b0010);
        check("t4_pend_kept", 32'(pending), 4'b0010);
        for (int i = 0; i < 2; i++) begin
            tick();
            check("t4_hold2_valid", 32'(gnt_valid), 1);
            check("t4_hold2_id", 32'(gnt_id), 1);
        end
        ovf_clr = 4'b0010;
        tick();
        ovf_clr = 4'b0000;
        check("t4_ovf_clr", 32'(overflow), 0);
        gnt_ready = 1'b1;
        tick();
        check("t4_accept_valid", 32'(gnt_valid), 0);
        check("t4_accept_pend", 32'(pending), 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t4_single_grant", 32'(gnt_valid), 0);
        end
        slow_pulse = 4'b0000;
        ticks(4);

        // ch2 event lands on the same edge as the ch2 accept
        gnt_ready  = 1'b0;
        slow_pulse = 4'b0100;
        ticks(4);
        check("t5_valid", 32'(gnt_valid), 1);
        check("t5_id", 32'(gnt_id), 2);
        slow_pulse = 4'b0000;
        ticks(4);
        slow_pulse = 4'b0100;
        ticks(2);
        gnt_ready = 1'b1;
        tick();
        check("t5_valid_drop", 32'(gnt_valid), 0);
        check("t5_pend_kept", 32'(pending), 4'b0100);
        check("t5_no_ovf", 32'(overflow), 0);
        expect_grant(2);
        check("t5_pend_clr", 32'(pending), 0);
        slow_pulse = 4'b0000;
        ticks(4);

        // Grant ch1, refill all four on its accept edge: order 2,3,0,1
        gnt_ready  = 1'b0;
        slow_pulse = 4'b0010;
        ticks(4);
        check("t6_valid", 32'(gnt_valid), 1);
        check("t6_id", 32'(gnt_id), 1);
        slow_pulse = 4'b0000;
        ticks(4);
        slow_pulse = 4'b1111;
        ticks(2);
        gnt_ready = 1'b1;
        tick();
        check("t6_pend_all", 32'(pending), 4'b1111);
        check("t6_no_ovf", 32'(overflow), 0);
        expect_grant(2);
        expect_grant(3);
        expect_grant(0);
        expect_grant(1);
        check("t6_pend_empty", 32'(pending), 0);
        slow_pulse = 4'b0000;
        ticks(4);

        // Asynchronous reset mid-grant withdraws the grant before the next edge
        gnt_ready  = 1'b0;
        slow_pulse = 4'b1000;
        ticks(4);
        check("t1b_valid_before", 32'(gnt_valid), 1);
        check("t1b_id_before", 32'(gnt_id), 3);
        #2;
        rst_n = 1'b0;
        #1;
        check("t1b_async_valid", 32'(gnt_valid), 0);
        check("t1b_async_pend", 32'(pending), 0);
        check("t1b_async_id", 32'(gnt_id), 0);
        slow_pulse = 4'b0000;
        tick();
        rst_n = 1'b1;
        ticks(5);
        check("t1b_post_valid", 32'(gnt_valid), 0);
        check("t1b_post_pend", 32'(pending), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
